axis_packetizer: RTL and testbench
==================================

Name: axis_packetizer

Overview:
- Stream stage that accepts raw 32-bit data beats on an AXI-Stream slave port and re-emits them on an AXI-Stream master port with tlast inserted every pkt_len beats.
- Sits between a raw data source (DMA read side or peripheral capture) and the downstream streaming data path, which expects framed packets.
- A registered skid buffer on the output gives full throughput with registered ready/valid.
- A packet counter and a busy flag are exported for the peripheral register block.

Parameters:
- DATA_W, 32, stream data width in bits.
- LEN_W, 8, width of pkt_len; maximum packet length is 2^LEN_W-1 beats.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous reset, active-high.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat ready.
- s_tdata  in  DATA_W  input beat data.
- s_tlast  in  1  early end-of-packet from the source.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  output beat ready.
- m_tdata  out  DATA_W  output beat data.
- m_tlast  out  1  output end-of-packet.
- pkt_len  in  LEN_W  beats per packet; 0 is treated as 1.
- pkt_count  out  CNT_W  number of completed output packets.
- busy  out  1  packet in progress or data held in the stage.

Behaviour:
- Reset (synchronous, active-high):
  - m_tvalid, m_tdata, m_tlast, pkt_count and busy all 0.
  - beat_cnt 0; both buffer slots empty.
  - s_tready is 0 during every reset cycle and is 1 on the first cycle after reset deasserts.
  - Reset mid-packet discards all buffered beats and the partial count. No tlast is emitted for the aborted packet.
- Input accept: an input beat is accepted on a cycle where s_tvalid and s_tready are both 1.
- Length latch: len_lat captures pkt_len (0 becomes 1) when a beat is accepted with beat_cnt==0. Changes to pkt_len mid-packet have no effect until the next packet starts.
- tlast generation, evaluated on the accepted beat:
  - last = s_tlast OR (beat_cnt == eff_len-1), where eff_len is the freshly captured length on the first beat and len_lat otherwise.
  - If last, beat_cnt returns to 0; otherwise beat_cnt increments.
  - pkt_len=1 therefore gives tlast on every beat.
  - s_tlast on the first beat gives a 1-beat packet.
- Output buffer (two slots: main and skid):
  - Latency is 1 cycle: a beat accepted at edge N drives m_tvalid/m_tdata/m_tlast after edge N.
  - s_tready is registered and equals NOT skid_valid.
  - If m_tready is low while main is valid, the incoming beat lands in skid and s_tready drops on the next cycle.
  - When main is handed off and skid is valid, skid moves to main and s_tready rises.
  - Sustained throughput is 1 beat/clk when m_tready is held at 1.
  - No beat is lost or duplicated under any m_tready pattern.
- AXI rules:
  - Once m_tvalid is 1, m_tdata and m_tlast hold stable until the handshake completes.
  - m_tvalid never depends combinationally on m_tready.
  - Simultaneous input accept and output handshake in the same cycle is legal and keeps occupancy constant.
- pkt_count: increments by 1 on every output handshake with m_tlast=1; wraps modulo 2^CNT_W.
- busy = (beat_cnt!=0) OR main_valid OR skid_valid.

Decomposition:
- Shared package axis_pkg: DATA_W default constant, axis_beat_t struct (data, last), LEN_W/CNT_W defaults.
- One sub-module, axis_skid_buffer: the 2-slot registered ready/valid stage carrying axis_beat_t, reusable elsewhere in the streaming path.
- The top level holds the length latch, beat counter, packet counter and busy logic.

Test Plan:
- pkt_len=4, 12 back-to-back beats 0x00..0x0B, m_tready=1 → m_tlast on beats 0x03, 0x07 and 0x0B; m_tvalid continuous from cycle 1; pkt_count=3.
- pkt_len=0, 3 beats → tlast on every beat; pkt_count=3.
- pkt_len=5, s_tlast on the 2nd beat, then 5 more beats → packets of 2 and 5 beats; tlast on beat indices 1 and 6; pkt_count=2.
- pkt_len=3, m_tready random 50%, 300 beats → output sequence identical to input; tlast every 3rd beat; s_tready never 1 while skid is full; pkt_count=100.
- Change pkt_len from 4 to 2 after the 1st beat of a packet → current packet still ends at 4 beats; following packets are 2 beats.
- Assert reset for 1 cycle after 2 beats of a 4-beat packet → m_tvalid=0 and busy=0 the next cycle; s_tready=1 the cycle after reset drops; the new stream restarts counting from beat 0.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream framing path.
// Contents:
//   AXIS_DATA_W / AXIS_LEN_W / AXIS_CNT_W : default widths for stream data,
//                                           packet length and packet counter
//   axis_beat_t                           : one stream beat (last flag + data)
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_LEN_W  = 8;
    localparam int AXIS_CNT_W  = 16;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-slot registered ready/valid stage (main + skid).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : upstream beat valid
//   in_ready    : upstream ready (from registered state only)
//   in_beat     : upstream beat payload
//   out_valid   : downstream beat valid (registered; main slot occupied)
//   out_ready   : downstream ready
//   out_beat    : downstream beat payload (main slot)
//   skid_full   : skid slot occupied; exported for occupancy/busy reporting
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and payload stable until that edge; ready
// may change at any time and never feeds back into valid.
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter type T = axis_beat_t
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_beat,
    output logic out_valid,
    input  logic out_ready,
    output T     out_beat,
    output logic skid_full
);

    logic main_valid;
    logic skid_valid;
    T     main_beat;
    T     skid_beat;

    logic in_fire;
    logic out_fire;

    // Ready is a pure function of stored state, forced low while reset is
    // held so nothing is accepted during reset and it rises the first cycle
    // after reset releases.
    assign in_ready  = ~skid_valid & ~reset;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;

    assign out_valid = main_valid;
    assign out_beat  = main_beat;
    assign skid_full = skid_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_beat  <= '0;
            skid_beat  <= '0;
        end else if (!main_valid || out_fire) begin
            // Main slot is free for the next cycle: refill from skid first
            // to preserve order, else straight from the input.
            if (skid_valid) begin
                main_beat  <= skid_beat;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_beat  <= in_beat;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            // Main is stalled; the beat accepted this cycle parks in skid.
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// Re-frames a raw AXI-Stream into packets of pkt_len beats by inserting
// tlast, with an early end-of-packet from the source honoured.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   s_tvalid/s_tready   : input stream handshake
//   s_tdata, s_tlast    : input beat data, early end-of-packet
//   m_tvalid/m_tready   : output stream handshake
//   m_tdata, m_tlast    : output beat data, end-of-packet
//   pkt_len             : beats per packet (0 behaves as 1), sampled at the
//                         first beat of each packet
//   pkt_count           : completed output packets, wraps
//   busy                : packet in progress or beats held in the stage
module axis_packetizer
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int LEN_W  = AXIS_LEN_W,
    parameter int CNT_W  = AXIS_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              busy
);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_lat;
    logic [LEN_W-1:0] len_now;
    logic [LEN_W-1:0] eff_len;
    logic             accept;
    logic             is_last;
    logic             skid_full;
    beat_t            in_beat;
    beat_t            out_beat;

    assign accept  = s_tvalid & s_tready;
    assign len_now = (pkt_len == '0) ? LEN_W'(1) : pkt_len;

    // The first beat of a packet uses the live length; later beats use the
    // value latched on that first beat, so mid-packet changes are ignored.
    assign eff_len = (beat_cnt == '0) ? len_now : len_lat;
    assign is_last = s_tlast | (beat_cnt == eff_len - LEN_W'(1));

    assign in_beat.data = s_tdata;
    assign in_beat.last = is_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            len_lat  <= '0;
        end else if (accept) begin
            if (beat_cnt == '0) begin
                len_lat <= len_now;
            end
            beat_cnt <= is_last ? '0 : beat_cnt + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (m_tvalid && m_tready && m_tlast) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

    axis_skid_buffer #(
        .T (beat_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_tvalid),
        .in_ready  (s_tready),
        .in_beat   (in_beat),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_beat  (out_beat),
        .skid_full (skid_full)
    );

    assign m_tdata = out_beat.data;
    assign m_tlast = out_beat.last;

    // m_tvalid is exactly the main-slot occupancy flag.
    assign busy = (beat_cnt != '0) | m_tvalid | skid_full;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: expected beats (data + hand-computed
// tlast) are queued when the input handshake happens and matched in order
// against every output handshake.
module tb_axis_packetizer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic [LEN_W-1:0]  pkt_len;
    logic [CNT_W-1:0]  pkt_count;
    logic              busy;

    logic              rand_mode = 1'b0;
    logic              rdy_force = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DATA_W:0] exp_q[$];
    int              hs_cyc[$];

    axis_packetizer #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .pkt_len   (pkt_len),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    // ---------------- clock / reset block ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream ready: either a fixed level or a random 50% pattern.
    always @(posedge clk) begin
        #1;
        m_tready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Sampled at negedge: a handshake seen here completes on the next posedge.
    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("extra_beat", {31'd0, m_tlast, m_tdata}, 64'hdead);
            end else begin
                chk("out_beat", {31'd0, m_tlast, m_tdata}, {31'd0, exp_q.pop_front()});
            end
        end
        if (rand_mode) begin
            chk("ready_vs_skid", 64'(s_tready & dut.u_skid.skid_valid), 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic tl, input logic exp_last);
        logic got;
        got      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = tl;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (s_tready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (got) begin
            exp_q.push_back({exp_last, d});
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout", 64'd0, 64'd1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        pkt_len  = 8'd4;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_s_tready", 64'(s_tready), 64'd1);

        // pkt_len=4, 12 back-to-back beats, tlast on 3, 7, 11
        hs_cyc.delete();
        for (int i = 0; i < 12; i++) begin
            send_beat(DATA_W'(i), 1'b0, (i % 4) == 3);
            if (i == 0) begin
                chk("latency_valid", 64'(m_tvalid), 64'd1);
                chk("latency_data", 64'(m_tdata), 64'd0);
            end
        end
        drain();
        chk("t1_hs_count", 64'(hs_cyc.size()), 64'd12);
        chk("t1_back_to_back", 64'(hs_cyc[11] - hs_cyc[0]), 64'd11);
        chk("t1_pkt_count", 64'(pkt_count), 64'd3);
        chk("t1_busy", 64'(busy), 64'd0);

        // pkt_len=0 behaves as 1
        pkt_len = 8'd0;
        for (int i = 0; i < 3; i++) send_beat(32'h20 + DATA_W'(i), 1'b0, 1'b1);
        drain();
        chk("t2_pkt_count", 64'(pkt_count), 64'd6);

        // pkt_len=5 with an early s_tlast on the 2nd beat
        pkt_len = 8'd5;
        send_beat(32'h30, 1'b0, 1'b0);
        send_beat(32'h31, 1'b1, 1'b1);
        for (int i = 2; i < 7; i++) send_beat(32'h30 + DATA_W'(i), 1'b0, i == 6);
        drain();
        chk("t3_pkt_count", 64'(pkt_count), 64'd8);

        // pkt_len=3, random downstream stalls, 300 beats
        pkt_len   = 8'd3;
        rand_mode = 1'b1;
        hs_cyc.delete();
        for (int i = 0; i < 300; i++) send_beat(32'h1000 + DATA_W'(i), 1'b0, (i % 3) == 2);
        rand_mode = 1'b0;
        rdy_force = 1'b1;
        drain();
        chk("t4_hs_count", 64'(hs_cyc.size()), 64'd300);
        chk("t4_pkt_count", 64'(pkt_count), 64'd108);
        chk("t4_busy", 64'(busy), 64'd0);

        // pkt_len change mid-packet takes effect at the next packet
        pkt_len = 8'd4;
        send_beat(32'h40, 1'b0, 1'b0);
        pkt_len = 8'd2;
        send_beat(32'h41, 1'b0, 1'b0);
        send_beat(32'h42, 1'b0, 1'b0);
        send_beat(32'h43, 1'b0, 1'b1);
        send_beat(32'h44, 1'b0, 1'b0);
        send_beat(32'h45, 1'b0, 1'b1);
        send_beat(32'h46, 1'b0, 1'b0);
        send_beat(32'h47, 1'b0, 1'b1);
        drain();
        chk("t5_pkt_count", 64'(pkt_count), 64'd111);

        // Reset mid-packet with both slots occupied
        pkt_len   = 8'd4;
        rdy_force = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_beat(32'h50, 1'b0, 1'b0);
        send_beat(32'h51, 1'b0, 1'b0);
        chk("t6_skid_full_ready", 64'(s_tready), 64'd0);
        chk("t6_busy_held", 64'(busy), 64'd1);
        chk("t6_hold_valid", 64'(m_tvalid), 64'd1);
        @(posedge clk);
        #1;
        chk("t6_hold_data", 64'(m_tdata), 64'h50);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_s_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_pkt_count", 64'(pkt_count), 64'd0);
        chk("t6_s_tready", 64'(s_tready), 64'd1);
        rdy_force = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(32'h60 + DATA_W'(i), 1'b0, i == 3);
        drain();
        chk("t6_new_pkt_count", 64'(pkt_count), 64'd1);
        chk("t6_final_busy", 64'(busy), 64'd0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
